// File: rtl/twelve_state_counter_pkg.sv
// Shared definitions for the modulo-12 counter family.
// Holds the default geometry of the counter and a helper that turns a
// modulus into the terminal-count value, so sibling counters built from
// the same parts agree on where the wrap happens.
package twelve_state_counter_pkg;

  localparam int MODULUS_DEFAULT = 12;
  localparam int WIDTH_DEFAULT   = 4;
  localparam int TC_VALUE        = MODULUS_DEFAULT - 1;

  // Last legal state of a counter with the given number of states.
  function automatic int tcOf(input int modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/twelve_state_counter_tc_decode.sv
// Terminal-count decode shared by counters of this family.
// Ports:
//   count_i  current counter state
//   en_i     count enable of this stage
//   tc_o     high while enabled and sitting on the terminal value, i.e. the
//            next edge wraps this stage and should advance the next one
module twelve_state_counter_tc_decode
  import twelve_state_counter_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int MODULUS = MODULUS_DEFAULT
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             en_i,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] TC = WIDTH'(tcOf(MODULUS));

  // Purely combinational so the carry appears in the same cycle as the
  // enable that will cause the wrap.
  always_comb begin
    tc_o = en_i & (count_i == TC);
  end

endmodule

// File: rtl/twelve_state_counter.sv
// Modulo-MODULUS up-counter with count enable and cascade carry.
// Ports:
//   clk     system clock, state changes on the rising edge
//   rstb    asynchronous active-low reset, clears count immediately
//   cnt_en  count enable, sampled on the rising edge
//   count   registered counter state, 0 .. MODULUS-1
//   y       carry: cnt_en while count is at MODULUS-1 (combinational)
module twelve_state_counter
  import twelve_state_counter_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int MODULUS = MODULUS_DEFAULT
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             cnt_en,
  output logic [WIDTH-1:0] count,
  output logic             y
);

  localparam logic [WIDTH-1:0] TC = WIDTH'(tcOf(MODULUS));

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next state. Comparing with >= rather than == means any unreachable
  // encoding above the terminal value also loads 0 on the next enabled
  // edge, so the counter recovers on its own from a corrupted state.
  always_comb begin
    count_d = count_q;
    if (cnt_en) begin
      if (count_q >= TC) begin
        count_d = '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  // State register; reset wins over any count in progress and does not
  // depend on cnt_en, so an unknown enable during reset still gives 0.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

  twelve_state_counter_tc_decode #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_tc_decode (
    .count_i (count_q),
    .en_i    (cnt_en),
    .tc_o    (y)
  );

endmodule

// File: tb/tb_twelve_state_counter.sv
// Scoreboard bench for twelve_state_counter.
// The stimulus process applies inputs shortly after each rising edge and
// pushes the response the counter should show for that cycle; a monitor
// on the falling edge pops and compares.
module tb_twelve_state_counter;

  localparam int MOD = 12;
  localparam int W   = 4;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         carry;
  } expect_t;

  logic         clk;
  logic         rstb;
  logic         cnt_en;
  logic [W-1:0] count;
  logic         y;

  int checks = 0;
  int errors = 0;

  expect_t expQ[$];

  int   model    = 0;
  logic prevEn   = 1'b0;
  logic prevRst  = 1'b0;

  twelve_state_counter #(
    .WIDTH   (W),
    .MODULUS (MOD)
  ) dut (
    .clk    (clk),
    .rstb   (rstb),
    .cnt_en (cnt_en),
    .count  (count),
    .y      (y)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counting rule: step up until the last state, anything at or past it
  // goes to 0.
  function automatic int advance(input int c);
    if (c < MOD - 1) return c + 1;
    return 0;
  endfunction

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Account for the edge that just happened, using the inputs that were
  // stable across it.
  task automatic modelEdge();
    if (!prevRst) model = 0;
    else if (prevEn === 1'b1) model = advance(model);
  endtask

  task automatic pushExpect(input logic en);
    expect_t e;
    e.cnt   = W'(model);
    e.carry = (en === 1'b1) && (model == MOD - 1);
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic en, input logic rst);
    @(posedge clk);
    modelEdge();
    #2;
    cnt_en = en;
    rstb   = rst;
    if (!rst) model = 0;
    prevEn  = en;
    prevRst = rst;
    #1;
    pushExpect(en);
  endtask

  // Reset asserted in the middle of a cycle must clear the count at once.
  task automatic asyncResetMidCycle(input int expectBefore);
    @(posedge clk);
    modelEdge();
    #3;
    checkOutput("count_before_async_reset", int'(count), expectBefore);
    #1;
    rstb = 1'b0;
    #1;
    checkOutput("count_async_reset", int'(count), 0);
    checkOutput("y_async_reset", int'(y), 0);
    model   = 0;
    prevRst = 1'b0;
  endtask

  // Corrupt the state register with an unreachable encoding.
  task automatic forceIllegal(input int val);
    @(posedge clk);
    modelEdge();
    #2;
    force dut.count_q = W'(val);
    #1;
    release dut.count_q;
    model = val;
    pushExpect(cnt_en);
  endtask

  // Monitor: one comparison pair per cycle that has an expectation.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("count", int'(count), int'(e.cnt));
        checkOutput("y", int'(y), int'(e.carry));
      end
    end
  end

  initial begin
    int guard;
    logic en;
    logic rst;
    rstb   = 1'b0;
    cnt_en = 1'b0;

    // Held in reset with the clock running.
    repeat (3) applyStimulus(1'b0, 1'b0);

    // Release, single enabled edge, then hold.
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b1);

    // Three enabled edges, hold, then two more.
    repeat (3) applyStimulus(1'b1, 1'b1);
    repeat (5) applyStimulus(1'b0, 1'b1);
    repeat (2) applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);

    // Count is 6 here; reset it between edges.
    asyncResetMidCycle(6);
    applyStimulus(1'b0, 1'b0);

    // Unknown enable while in reset.
    applyStimulus(1'bx, 1'b0);

    // Release with enable held: full sequence and wrap.
    repeat (MOD) applyStimulus(1'b1, 1'b1);
    repeat (MOD - 1) applyStimulus(1'b1, 1'b1);

    // Park on the terminal value: carry stays low while disabled.
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);

    // Illegal encodings recover to 0 on an enabled edge, hold otherwise.
    applyStimulus(1'b1, 1'b1);
    forceIllegal(14);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    forceIllegal(15);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);

    // Random enables with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 49) != 0);
      applyStimulus(en, rst);
    end

    // Let the monitor consume what is left, with a bounded wait.
    guard = 0;
    while (expQ.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
